// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit.
//   mem_state_t : FSM states (IDLE, ACCESS, DONE)
//   mem_cmd_t   : decoded command from the mem_read/mem_write flag pair
//   DATA_W_DEF  : default data/address width
package mem_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RD   = 2'd1,
        CMD_WR   = 2'd2,
        CMD_BAD  = 2'd3
    } mem_cmd_t;

    function automatic mem_cmd_t decode_cmd(input logic rd, input logic wr);
        mem_cmd_t c;
        case ({rd, wr})
            2'b10:   c = CMD_RD;
            2'b01:   c = CMD_WR;
            2'b11:   c = CMD_BAD;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
//   mem_en    : request, held high for the whole access
//   mem_wr    : 1 = write, 0 = read
//   mem_addr  : address
//   mem_wdata : store data
//   mem_rdata : read data, valid when mem_ready=1
//   mem_ready : completion from memory
interface mem_access_unit_if #(
    parameter int DATA_W = mem_pkg::DATA_W_DEF
) ();
    logic              mem_en;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit_timeout_counter.sv
// Access timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (held while not accessing)
//   en       : count one cycle of ACCESS
//   expired  : the current ACCESS cycle is the TIMEOUT-th one
module timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    import mem_pkg::*;

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    // cnt holds the number of ACCESS cycles already completed, so the
    // abort fires on the edge that would bring the count up to TIMEOUT.
    assign expired = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one load/store per command against a
// variable-latency memory, with pass-through for non-memory instructions.
//   clk, rst    : clock, synchronous active-high reset
//   start       : command valid, sampled only in IDLE
//   alu_result  : address, or pass-through value
//   wr_data     : store data
//   mem_read/mem_write : command flags
//   busy        : state != IDLE
//   done        : one-cycle completion pulse
//   rd_data     : writeback value, held after done
//   err         : failure flag, only during done
//   mem         : memory bus (master side)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    mem_access_unit_if.master mem
);

    mem_state_t        state_q, state_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic              expired;

    timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != ACCESS),
        .en      (state_q == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = 1'b0;   // err is only ever set for the single DONE cycle
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = alu_result;
                    wdata_d = wr_data;
                    case (decode_cmd(mem_read, mem_write))
                        CMD_RD:   begin state_d = ACCESS; wr_d = 1'b0; end
                        CMD_WR:   begin state_d = ACCESS; wr_d = 1'b1; end
                        CMD_NONE: begin state_d = DONE;   rd_d = alu_result; end
                        default:  begin state_d = DONE;   err_d = 1'b1; end
                    endcase
                end
            end
            ACCESS: begin
                // ready is checked first so it wins over a coincident timeout
                if (mem.mem_ready) begin
                    state_d = DONE;
                    if (!wr_q)
                        rd_d = mem.mem_rdata;
                end else if (expired) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign rd_data       = rd_q;
    assign mem.mem_en    = (state_q == ACCESS);
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst, start, mem_read, mem_write;
    logic [DW-1:0] alu_result, wr_data, rd_data;
    logic          busy, done, err;

    mem_access_unit_if #(.DATA_W(DW)) bus ();

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alu_result (alu_result),
        .wr_data    (wr_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .err        (err),
        .mem        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;
    exp_t sb[$];

    // memory model configuration
    int            ready_at  = 0;   // 0 = never ready
    logic [DW-1:0] rdata_cfg = '0;
    int            en_cnt    = 0;
    int            en_total  = 0;
    logic [DW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          exp_wr    = 1'b0;
    logic [DW-1:0] model_rd  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // variable-latency memory: ready on the ready_at-th mem_en cycle
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            en_cnt++;
            en_total++;
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("mem_wr", 32'(bus.mem_wr), 32'(exp_wr));
            if (exp_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        end else begin
            en_cnt = 0;
        end
        bus.mem_ready = (bus.mem_en === 1'b1) && (ready_at != 0) && (en_cnt == ready_at);
        bus.mem_rdata = rdata_cfg;
    end

    // scoreboard: every done must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_done: observed done=1 expected no pending command");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.rd));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic run_cmd(input logic rd, input logic wr, input logic [DW-1:0] alu,
                           input logic [DW-1:0] wd, input int rdy, input logic [DW-1:0] rdat,
                           input int exp_lat, input int exp_en);
        exp_t e;
        int   lat;
        e.err = 1'b0;
        if (rd && wr) begin
            e.err = 1'b1;
        end else if (!rd && !wr) begin
            model_rd = alu;
        end else if (rdy >= 1 && rdy <= TO) begin
            if (rd) model_rd = rdat;
        end else begin
            model_rd = '0;
            e.err    = 1'b1;
        end
        e.rd = model_rd;
        sb.push_back(e);
        exp_addr = alu; exp_wdata = wd; exp_wr = wr;
        ready_at = rdy; rdata_cfg = rdat; en_total = 0;
        @(negedge clk);
        start = 1'b1; mem_read = rd; mem_write = wr; alu_result = alu; wr_data = wd;
        @(negedge clk);
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("err_after", 32'(err), 32'd0);
        chk("mem_en_cycles", 32'(en_total), 32'(exp_en));
        chk("rd_hold", 32'(rd_data), 32'(model_rd));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // load, 3-cycle memory
        run_cmd(1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF, 4, 3);
        // store, zero-wait memory
        run_cmd(1'b0, 1'b1, 16'h0012, 16'h1234, 1, 16'h9999, 2, 1);
        // pass-through
        run_cmd(1'b0, 1'b0, 16'hA5A5, 16'h0000, 1, 16'h0000, 1, 0);

        // illegal command, then a start during DONE that must be ignored
        begin
            exp_t e;
            e.rd = model_rd; e.err = 1'b1;
            sb.push_back(e);
            en_total = 0; ready_at = 1;
            @(negedge clk);
            start = 1'b1; mem_read = 1'b1; mem_write = 1'b1; alu_result = 16'h0F0F;
            @(negedge clk);
            chk("bad_done_c1", 32'(done), 32'd1);
            chk("bad_err_c1", 32'(err), 32'd1);
            mem_write = 1'b0; alu_result = 16'h0077;   // a load, presented while busy
            @(negedge clk);
            start = 1'b0; mem_read = 1'b0;
            chk("ignored_busy", 32'(busy), 32'd0);
            repeat (4) @(negedge clk);
            chk("ignored_mem_en", 32'(en_total), 32'd0);
            chk("ignored_rd", 32'(rd_data), 32'(model_rd));
        end

        // timeout: memory never ready
        run_cmd(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h5555, 5, 4);
        // store whose ready coincides with the timeout edge: ready wins
        run_cmd(1'b0, 1'b1, 16'h0044, 16'h7777, 4, 16'h0000, 5, 4);

        // reset in cycle 2 of a load
        exp_addr = 16'h0200; exp_wr = 1'b0; ready_at = 0; en_total = 0;
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; alu_result = 16'h0200;
        @(negedge clk);
        start = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rstacc_busy", 32'(busy), 32'd0);
        chk("rstacc_done", 32'(done), 32'd0);
        chk("rstacc_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstacc_rd", 32'(rd_data), 32'd0);
        chk("rstacc_en_cycles", 32'(en_total), 32'd2);
        model_rd = '0;
        repeat (3) @(negedge clk);
        run_cmd(1'b1, 1'b0, 16'h0300, 16'h0000, 2, 16'hCAFE, 3, 2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit for the 16-bit unpipelined MIPS-style processor. It consumes the execute stage's result (`alu_result` as address or pass-through value, `data2` as store data) and runs one load or store per instruction against a variable-latency data memory via an enable/ready handshake. It returns a single-cycle `done` pulse with the writeback value, or an error on an illegal command or a memory timeout.

## Interface
Parameters:
- `DATA_W`, 16: data and address width
- `TIMEOUT`, 255: maximum cycles spent in ACCESS before abort (1..255)

Ports:
- `clk`, in, 1: single clock, rising edge
- `rst`, in, 1: synchronous, active-high reset
- `start`, in, 1: command valid; sampled only in IDLE
- `alu_result`, in, DATA_W: address for load/store, or pass-through value
- `wr_data`, in, DATA_W: store data
- `mem_read`, in, 1: command is a load
- `mem_write`, in, 1: command is a store
- `busy`, out, 1: high whenever state ≠ IDLE
- `done`, out, 1: one-cycle completion pulse
- `rd_data`, out, DATA_W: writeback value, valid while `done`=1; holds its value afterwards
- `err`, out, 1: high for exactly the cycle in which `done` is high when the command failed
- `mem_en`, out, 1: memory request, held high through the ACCESS state
- `mem_wr`, out, 1: 1 = write, 0 = read; valid while `mem_en`=1
- `mem_addr`, out, DATA_W: latched address
- `mem_wdata`, out, DATA_W: latched store data
- `mem_rdata`, in, DATA_W: read data, valid in the cycle `mem_ready`=1
- `mem_ready`, in, 1: memory completion, sampled only while `mem_en`=1

## Operation
- States: IDLE, ACCESS, DONE.
- Reset: state=IDLE; all outputs 0 (`busy`, `done`, `err`, `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `rd_data`); timeout counter 0.
- In IDLE with `start`=1, the command is decoded and `alu_result`/`wr_data` are latched:
  - `mem_read`=1, `mem_write`=0: go to ACCESS; `mem_wr`=0.
  - `mem_write`=1, `mem_read`=0: go to ACCESS; `mem_wr`=1.
  - Neither set: go to DONE with `rd_data`=`alu_result` and `err`=0 (non-memory instruction pass-through).
  - Both set: go to DONE with `err`=1 and `rd_data` unchanged. No memory access is made.
- In ACCESS: `mem_en`=1 and the counter increments each cycle.
  - `mem_ready`=1 sampled: go to DONE. A load captures `rd_data`=`mem_rdata`. A store leaves `rd_data` unchanged. `err`=0.
  - Counter reaches TIMEOUT without `mem_ready`: go to DONE with `err`=1 and `rd_data`=0.
  - If `mem_ready` and the timeout occur on the same edge, `mem_ready` wins.
- DONE lasts exactly one cycle (`done`=1), then returns to IDLE. The counter clears on entry to IDLE.
- `start` outside IDLE is ignored; no queuing.
- `mem_ready` while `mem_en`=0 is ignored.
- `rst` during ACCESS: `mem_en` drops on the next edge and no `done` is produced.

## Timing
- All outputs are registered.
- Memory command:
  - Edge 0 samples `start`.
  - `mem_en` is high from cycle 1.
  - If `mem_ready` is high in cycle k (k ≥ 1), `mem_en` is low and `done` is high in cycle k+1.
  - Minimum start-to-done latency is 2 cycles.
- Pass-through and illegal commands: `done` is high in cycle 1 (latency 1).
- Timeout: `mem_en` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); `done`/`err` are high in cycle TIMEOUT+1.
- The earliest next accepted `start` is sampled at the edge that ends DONE, i.e. `busy` low in the following cycle.
- `mem_addr`, `mem_wdata` and `mem_wr` are stable for the whole time `mem_en` is high.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` {IDLE, ACCESS, DONE}
  - command decode constants CMD_NONE, CMD_RD, CMD_WR, CMD_BAD
  - default `DATA_W`
- One sub-module, `timeout_counter`: 8-bit counter with clear, enable, and an `expired` output compared against TIMEOUT.
- The rest is a single FSM with its latch registers.

## Test plan
- Load, 3-cycle memory: start with `mem_read`=1, `alu_result`=0x0040; memory asserts `mem_ready` on the 3rd `mem_en` cycle with `mem_rdata`=0xBEEF. Required: `mem_addr`=0x0040, `mem_wr`=0, `done` in cycle 4, `rd_data`=0xBEEF, `err`=0.
- Store, zero-wait memory: start with `mem_write`=1, `alu_result`=0x0012, `wr_data`=0x1234; `mem_ready`=1 in cycle 1. Required: `mem_wr`=1, `mem_wdata`=0x1234, `done` in cycle 2, `rd_data` unchanged.
- Pass-through: start with both flags 0, `alu_result`=0xA5A5. Required: `done` in cycle 1, `rd_data`=0xA5A5, `mem_en` never high.
- Illegal command and ignored restart:
  - Start with both flags 1. Required: `done`+`err` in cycle 1, no `mem_en`.
  - Then assert `start` again while `busy`. Required: it is ignored.
- Timeout: TIMEOUT=4, load, `mem_ready` held 0. Required: `mem_en` high for cycles 1–4, `done`=`err`=1 in cycle 5, `rd_data`=0.
- Reset mid-access: `rst` in cycle 2 of a load. Required: `mem_en`=0 next cycle, all outputs 0, no `done`; a new load afterwards completes normally.
